// File: rtl/aq_spsram_1024x64_ctrl_pkg.sv
// Shared types and constants for the 1024x64 single-port SRAM request controller.
package aq_spsram_1024x64_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10
  } ctrl_st_e;

  localparam int RAM_DEPTH = 1024;
  localparam int BE_WIDTH  = 8;

  // Byte enables (active-high) expanded to the macro's active-low bit-write enables.
  function automatic logic [BE_WIDTH*8-1:0] be_to_wen(input logic [BE_WIDTH-1:0] be);
    logic [BE_WIDTH*8-1:0] wen;
    for (int i = 0; i < BE_WIDTH; i++) wen[8*i +: 8] = {8{~be[i]}};
    return wen;
  endfunction

endpackage

// File: rtl/aq_spsram_1024x64_ctrl_rsp_fifo.sv
// Small synchronous response FIFO; push and pop may coincide, including when full.
module aq_spsram_1024x64_ctrl_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = nxt(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = nxt(rd_ptr_q);
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/aq_spsram_1024x64_ctrl.sv
// Valid/ready request front end for the 1024x64 SRAM macro: zero-fill after reset,
// then one access per cycle with credit-limited reads returned through a small FIFO.
module aq_spsram_1024x64_ctrl
  import aq_spsram_1024x64_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RSP_DEPTH  = 3,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  ctrl_st_e              st_q, st_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  run, acc_rd, acc_wr, pop, fifo_full, fifo_empty;

  assign run       = (st_q == ST_RUN);
  assign init_done = run;
  // Credits only look at registered state, so rsp_rdy never reaches req_rdy.
  assign req_rdy   = run && (req_wr || ((outst_q < CW'(RSP_DEPTH)) && !fifo_full));
  assign acc_wr    = req_vld && req_rdy && req_wr;
  assign acc_rd    = req_vld && req_rdy && !req_wr;
  assign rsp_vld   = !fifo_empty;
  assign pop       = rsp_vld && rsp_rdy;
  assign rd_pend_d = acc_rd;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      ST_RST: begin
        cnt_d = '0;
        st_d  = (INIT_EN != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) st_d = ST_RUN;
      end
      ST_RUN:  st_d = ST_RUN;
      default: st_d = ST_RST;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (acc_rd && !pop) outst_d = outst_q + 1'b1;
    else if (!acc_rd && pop) outst_d = outst_q - 1'b1;
  end

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
    if (st_q == ST_INIT) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = cnt_q;
    end else if (acc_wr && (req_be != '0)) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = be_to_wen(req_be);
      ram_a    = req_addr;
      ram_d    = req_wdata;
    end else if (acc_rd) begin
      ram_cen  = 1'b0;
      ram_a    = req_addr;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      st_q      <= ST_RST;
      cnt_q     <= '0;
      outst_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Macro Q is valid the cycle after the read enable, so capture it one cycle late.
  aq_spsram_1024x64_ctrl_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .push  (rd_pend_q),
    .din   (ram_q),
    .pop   (pop),
    .dout  (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_aq_spsram_1024x64_ctrl.sv
// Bench for the SRAM request controller: behavioural macro, request-level reference memory.
module tb_aq_spsram_1024x64_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b0;
  logic        req_rdy, rsp_vld, init_done, ram_cen, ram_gwen;
  logic [9:0]  req_addr = '0, ram_a;
  logic [63:0] req_wdata = '0, rsp_rdata, ram_wen, ram_d, ram_q;
  logic [7:0]  req_be = '0;

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [1024];
  logic [63:0] expq [$];
  logic [63:0] sram [1024];

  always #5 clk = ~clk;

  aq_spsram_1024x64_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .ram_a          (ram_a),
    .ram_cen        (ram_cen),
    .ram_gwen       (ram_gwen),
    .ram_wen        (ram_wen),
    .ram_d          (ram_d),
    .ram_q          (ram_q)
  );

  // Macro model: bit-masked write, registered read data.
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_rst_vals();
    chk("rst_req_rdy",   64'(req_rdy),   64'(0));
    chk("rst_rsp_vld",   64'(rsp_vld),   64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_rdata",     rsp_rdata,      64'(0));
    chk("rst_cen",       64'(ram_cen),   64'(1));
    chk("rst_gwen",      64'(ram_gwen),  64'(1));
    chk("rst_wen",       ram_wen,        64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_a",         64'(ram_a),     64'(0));
    chk("rst_d",         ram_d,          64'(0));
  endtask

  // One clock of RUN traffic; inputs are set by the caller just after a falling edge.
  task automatic tick(output bit acc);
    logic [63:0] ew;
    bit pop;
    #1;
    acc = req_vld && req_rdy;
    pop = rsp_vld && rsp_rdy;
    chk("req_rdy", 64'(req_rdy), 64'(req_wr || (expq.size() < 3)));
    if (pop) begin
      if (expq.size() == 0) chk("spurious_vld", 64'(rsp_vld), 64'(0));
      else chk("rdata", rsp_rdata, expq.pop_front());
    end
    if (acc && req_wr) begin
      for (int i = 0; i < 8; i++) begin
        ew[8*i +: 8] = {8{~req_be[i]}};
        if (req_be[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end
      chk("wr_cen", 64'(ram_cen), 64'(req_be == 8'h00));
      if (req_be != 8'h00) begin
        chk("wr_gwen", 64'(ram_gwen), 64'(0));
        chk("wr_wen",  ram_wen, ew);
        chk("wr_a",    64'(ram_a), 64'(req_addr));
        chk("wr_d",    ram_d, req_wdata);
      end
    end else if (acc) begin
      expq.push_back(ref_mem[req_addr]);
      chk("rd_cen",  64'(ram_cen),  64'(0));
      chk("rd_gwen", 64'(ram_gwen), 64'(1));
      chk("rd_a",    64'(ram_a),    64'(req_addr));
    end else begin
      chk("idle_cen", 64'(ram_cen), 64'(1));
    end
    @(negedge clk);
  endtask

  task automatic do_wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
    bit acc;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    tick(acc);
    req_vld = 1'b0;
    chk("wr_acc", 64'(acc), 64'(1));
  endtask

  task automatic do_rd(input logic [9:0] a);
    bit acc;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    tick(acc);
    req_vld = 1'b0;
    chk("rd_acc", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    bit acc;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) tick(acc);
    chk("drain_left", 64'(expq.size()), 64'(0));
    chk("drain_vld",  64'(rsp_vld), 64'(0));
  endtask

  // Release reset at a falling edge and follow the zero-fill; optionally abort at entry 500.
  task automatic init_seq(input bit abort_mid);
    int ncen = 0, first = 0, done_cyc = 0, exp_a = 0;
    bit ok = 1'b1, vld_seen = 1'b0;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 1100 && done_cyc == 0; c++) begin
      #1;
      if (rsp_vld) vld_seen = 1'b1;
      if (init_done) done_cyc = c;
      else if (!ram_cen) begin
        if (ram_a != exp_a[9:0] || ram_wen != '0 || ram_gwen || ram_d != '0) ok = 1'b0;
        if (ncen == 0) first = c;
        if (abort_mid && ram_a == 10'd500) begin
          chk("abort_prefix", 64'(ok), 64'(1));
          rst = 1'b1;
          #1;
          check_rst_vals();
          @(negedge clk);
          @(negedge clk);
          return;
        end
        ncen++;
        exp_a++;
      end
      @(negedge clk);
    end
    chk("init_first_cyc", 64'(first),    64'(2));
    chk("init_writes",    64'(ncen),     64'(1024));
    chk("init_pattern",   64'(ok),       64'(1));
    chk("init_done_cyc",  64'(done_cyc), 64'(1026));
    chk("init_no_vld",    64'(vld_seen), 64'(0));
    foreach (ref_mem[i]) ref_mem[i] = '0;
    expq.delete();
  endtask

  initial begin
    bit acc;
    int n;
    logic [63:0] held;

    @(negedge clk);
    #1;
    check_rst_vals();
    @(negedge clk);
    init_seq(1'b0);

    // Zero-filled top entry
    do_rd(10'h3FF);
    drain();

    // Partial write merge and minimum read latency
    rsp_rdy = 1'b0;
    do_wr(10'h005, 64'h1122334455667788, 8'hFF);
    do_wr(10'h005, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_rd(10'h005);
    #1;
    chk("lat_t1_vld", 64'(rsp_vld), 64'(0));
    @(negedge clk);
    #1;
    chk("lat_t2_vld", 64'(rsp_vld), 64'(1));
    chk("merge_data", rsp_rdata, 64'h11223344AAAAAAAA);
    @(negedge clk);
    drain();

    // Back-to-back reads, no bubbles
    for (int a = 0; a < 16; a++) do_wr(10'(a), {$urandom, $urandom}, 8'hFF);
    rsp_rdy = 1'b1;
    req_vld = 1'b1;
    req_wr  = 1'b0;
    for (int a = 0; a < 16; a++) begin
      req_addr = 10'(a);
      tick(acc);
      chk("b2b_acc", 64'(acc), 64'(1));
    end
    drain();

    // Credit stall, write during stall, then drain and resume
    rsp_rdy = 1'b0;
    req_vld = 1'b1;
    req_wr  = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 10'($urandom_range(0, 15));
      tick(acc);
      if (acc) n++;
    end
    chk("stall_accepts", 64'(n), 64'(3));
    held = rsp_rdata;
    do_wr(10'h009, {$urandom, $urandom}, 8'hFF);
    chk("stall_hold", rsp_rdata, held);
    rsp_rdy = 1'b1;
    req_vld = 1'b1;
    req_wr  = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      req_addr = 10'($urandom_range(0, 15));
      tick(acc);
      if (acc) n++;
    end
    chk("resume_accepts", 64'(n >= 8), 64'(1));
    drain();

    // Zero byte-enable write leaves the entry untouched
    do_wr(10'h007, 64'hDEADBEEFCAFEF00D, 8'hFF);
    do_wr(10'h007, 64'h0123456789ABCDEF, 8'h00);
    do_rd(10'h007);
    drain();

    // Random mixed traffic
    for (int i = 0; i < 1500; i++) begin
      req_vld   = ($urandom_range(0, 3) != 0);
      req_wr    = $urandom_range(0, 1) == 1;
      req_addr  = 10'($urandom_range(0, 31));
      req_wdata = {$urandom, $urandom};
      req_be    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rsp_rdy   = ($urandom_range(0, 2) != 0);
      tick(acc);
    end
    drain();

    // Reset mid-INIT, then a full zero-fill from entry 0
    rst = 1'b1;
    #1;
    check_rst_vals();
    @(negedge clk);
    @(negedge clk);
    init_seq(1'b1);
    init_seq(1'b0);

    // Reset with two responses buffered
    rsp_rdy = 1'b0;
    do_rd(10'h001);
    do_rd(10'h002);
    for (int i = 0; i < 3; i++) tick(acc);
    chk("buf_vld", 64'(rsp_vld), 64'(1));
    rst = 1'b1;
    #1;
    check_rst_vals();
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    init_seq(1'b0);
    do_rd(10'h002);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
